demux_1x2_reg: RTL

DEMUX_1X2_REG -- requirements
Module: demux_1x2_reg

---
 rtl/demux_1x2_reg_if.sv | 26 ++
 rtl/demux_1x2_reg.sv | 86 ++++++++
 2 files changed

// File: rtl/demux_1x2_reg_if.sv
// Handshake bundle for demux_1x2_reg: one input stream, two output channels.
// master = upstream producer plus both downstream consumers; slave = the demux.
interface demux_1x2_reg_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] i;
  logic             i_valid;
  logic             sel;
  logic             i_ready;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic             o1_valid;
  logic             o2_valid;
  logic             o1_ready;
  logic             o2_ready;

  modport master (
    output i, i_valid, sel, o1_ready, o2_ready,
    input  i_ready, o1, o2, o1_valid, o2_valid
  );

  modport slave (
    input  i, i_valid, sel, o1_ready, o2_ready,
    output i_ready, o1, o2, o1_valid, o2_valid
  );
endinterface

// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 demultiplexer: each channel is a single-entry holding register.
// Define DEMUX_1X2_CNT_EN to add 16-bit output handshake counters cnt1/cnt2.
module demux_1x2_reg #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  demux_1x2_reg_if.slave    bus
`ifdef DEMUX_1X2_CNT_EN
  ,
  output logic [15:0]       cnt1,
  output logic [15:0]       cnt2
`endif
);

  // state | meaning
  // EMPTY | holding register has no word, channel can always accept
  // FULL  | holding register presents a word to the downstream consumer
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chanState_t;

  chanState_t       state1, state2;
  chanState_t       state1Next, state2Next;
  logic [WIDTH-1:0] data1, data2;
  logic             inReady;
  logic             load1, load2;
  logic             drain1, drain2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state1 <= EMPTY;
      state2 <= EMPTY;
    end else begin
      state1 <= state1Next;
      state2 <= state2Next;
    end
  end

  // Ready looks only at the selected channel, never at i_valid.
  always_comb begin
    inReady    = bus.sel ? ((state2 == EMPTY) || bus.o2_ready)
                         : ((state1 == EMPTY) || bus.o1_ready);
    load1      = bus.i_valid & inReady & ~bus.sel;
    load2      = bus.i_valid & inReady &  bus.sel;
    drain1     = (state1 == FULL) & bus.o1_ready;
    drain2     = (state2 == FULL) & bus.o2_ready;
    state1Next = state1;
    state2Next = state2;
    if (load1)       state1Next = FULL;
    else if (drain1) state1Next = EMPTY;
    if (load2)       state2Next = FULL;
    else if (drain2) state2Next = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1 <= '0;
      data2 <= '0;
    end else begin
      if (load1) data1 <= bus.i;
      if (load2) data2 <= bus.i;
    end
  end

  assign bus.i_ready  = inReady;
  assign bus.o1       = data1;
  assign bus.o2       = data2;
  assign bus.o1_valid = (state1 == FULL);
  assign bus.o2_valid = (state2 == FULL);

`ifdef DEMUX_1X2_CNT_EN
  // Free-running handshake counters; natural 16-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (drain1) cnt1 <= cnt1 + 16'd1;
      if (drain2) cnt2 <= cnt2 + 16'd1;
    end
  end
`endif

endmodule
